// File: rtl/rom_scan_ctrl_if.sv
// Control, ROM-side and read-data bundle for rom_scan_ctrl.
interface rom_scan_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] step;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] data_addr;
  logic              data_valid;
  logic [15:0]       checksum;

  modport master (
    output start, stop, mode, step, rom_q,
    input  busy, done, rom_addr, data_out, data_addr, data_valid, checksum
  );

  modport slave (
    input  start, stop, mode, step, rom_q,
    output busy, done, rom_addr, data_out, data_addr, data_valid, checksum
  );
endinterface

// File: rtl/rom_scan_ctrl.sv
// ROM address sequencer (one-shot / loop / bounce) with read-latency aligned data output.
// Optional running checksum of read words enabled by macro ROM_CHECKSUM_EN.
module rom_scan_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  rom_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  localparam logic [ADDR_W:0] Last = (ADDR_W+1)'(DEPTH - 1);

  state_e                          r_state, w_state_d;
  logic [1:0]                      r_mode, w_mode_d;
  logic [ADDR_W-1:0]               r_step, w_step_d;
  logic [ADDR_W-1:0]               r_addr, w_addr_d;
  logic                            r_dir, w_dir_d;  // 0 = up, 1 = down
  logic                            r_busy, w_busy_d;
  logic                            r_done, w_done_d;
  logic                            w_issue;
  logic                            w_start_acc;
  logic [ADDR_W:0]                 w_addr_x, w_step_x, w_sum, w_diff;
  logic [RD_LAT-1:0]               r_pipe_v;
  logic [RD_LAT-1:0][ADDR_W-1:0]   r_pipe_a;
  logic [DATA_W-1:0]               r_data_out;
  logic [ADDR_W-1:0]               r_data_addr;
  logic                            r_data_valid;

  // Next-address arithmetic is one bit wider so overshoot past DEPTH-1 is visible.
  assign w_addr_x = {1'b0, r_addr};
  assign w_step_x = {1'b0, r_step};
  assign w_sum    = w_addr_x + w_step_x;
  assign w_diff   = w_addr_x - w_step_x;

  always_comb begin
    w_state_d   = r_state;
    w_mode_d    = r_mode;
    w_step_d    = r_step;
    w_addr_d    = r_addr;
    w_dir_d     = r_dir;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_issue     = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (bus.start && !r_done) begin
          w_start_acc = 1'b1;
          w_mode_d    = bus.mode;
          w_step_d    = (bus.step == '0) ? ADDR_W'(1) : bus.step;
          w_addr_d    = '0;
          w_dir_d     = 1'b0;
          w_busy_d    = 1'b1;
          w_state_d   = StScan;
        end
      end
      StScan: begin
        if (bus.stop) begin
          w_state_d = StDrain;
        end else begin
          w_issue = 1'b1;
          case (r_mode)
            2'b01: begin
              w_addr_d = (w_sum > Last) ? '0 : w_sum[ADDR_W-1:0];
            end
            2'b10: begin
              if (!r_dir) begin
                if (w_addr_x == Last) begin
                  w_dir_d  = 1'b1;
                  w_addr_d = (w_addr_x >= w_step_x) ? w_diff[ADDR_W-1:0] : '0;
                end else if (w_sum > Last) begin
                  w_addr_d = Last[ADDR_W-1:0];
                end else begin
                  w_addr_d = w_sum[ADDR_W-1:0];
                end
              end else begin
                if (r_addr == '0) begin
                  w_dir_d  = 1'b0;
                  w_addr_d = (w_step_x > Last) ? Last[ADDR_W-1:0] : r_step;
                end else if (w_addr_x < w_step_x) begin
                  w_addr_d = '0;
                end else begin
                  w_addr_d = w_diff[ADDR_W-1:0];
                end
              end
            end
            default: begin
              if (w_sum > Last) begin
                w_state_d = StDrain;
              end else begin
                w_addr_d = w_sum[ADDR_W-1:0];
              end
            end
          endcase
        end
      end
      StDrain: begin
        // Empty pipe means the final capture is happening (or happened); done follows.
        if (r_pipe_v == '0) begin
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_mode  <= 2'b00;
      r_step  <= '0;
      r_addr  <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_mode  <= w_mode_d;
      r_step  <= w_step_d;
      r_addr  <= w_addr_d;
      r_dir   <= w_dir_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_v     <= '0;
      r_pipe_a     <= '0;
      r_data_out   <= '0;
      r_data_addr  <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_pipe_v[0] <= w_issue;
      r_pipe_a[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_a[i] <= r_pipe_a[i-1];
      end
      r_data_valid <= r_pipe_v[RD_LAT-1];
      if (r_pipe_v[RD_LAT-1]) begin
        r_data_out  <= bus.rom_q;
        r_data_addr <= r_pipe_a[RD_LAT-1];
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= 16'h0000;
    end else if (w_start_acc) begin
      r_checksum <= 16'h0000;
    end else if (r_data_valid) begin
      r_checksum <= r_checksum + 16'(r_data_out);
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = 16'h0000;
`endif

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rom_addr   = r_addr;
  assign bus.data_out   = r_data_out;
  assign bus.data_addr  = r_data_addr;
  assign bus.data_valid = r_data_valid;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Scoreboard bench for rom_scan_ctrl: a list-based scan model feeds expected words,
// a negedge monitor pops and compares every data_valid.
module tb_rom_scan_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rom_scan_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_scan_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ROM macro model: q follows the address RD_LAT clocks later.
  logic [DATA_W-1:0] rom  [2**ADDR_W];
  logic [ADDR_W-1:0] hist [RD_LAT];
  always @(posedge clk) begin
    hist[0] <= bus.rom_addr;
    for (int i = 1; i < RD_LAT; i++) hist[i] <= hist[i-1];
  end
  assign bus.rom_q = rom[hist[RD_LAT-1]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_valid_cyc = -1;
  int last_valid_cyc  = -1;
  logic [DATA_W-1:0] exp_data [$];
  logic [ADDR_W-1:0] exp_addr [$];
  int                model_q  [$];
  logic [15:0]       prev_ck;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.data_valid === 1'b1) begin
      if (exp_data.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_valid: actual addr=%0d data=%0h required no word", bus.data_addr,
                 bus.data_out);
      end else begin
        check("data_out", 32'(bus.data_out), 32'(exp_data.pop_front()));
        check("data_addr", 32'(bus.data_addr), 32'(exp_addr.pop_front()));
      end
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
    end
  end

  // Address list from the scan rules: n = number of issues (0 = run one-shot to the end).
  task automatic build_model(input int md, input int st, input int n);
    int s, last;
    int up[$];
    int dn[$];
    model_q.delete();
    s = (st == 0) ? 1 : st;
    last = DEPTH - 1;
    if (md == 1) begin
      while (model_q.size() < n)
        for (int a = 0; a <= last && model_q.size() < n; a += s) model_q.push_back(a);
    end else if (md == 2) begin
      for (int a = s; a < last; a += s) up.push_back(a);
      up.push_back(last);
      for (int a = last - s; a > 0; a -= s) dn.push_back(a);
      dn.push_back(0);
      model_q.push_back(0);
      while (model_q.size() < n) begin
        foreach (up[i]) if (model_q.size() < n) model_q.push_back(up[i]);
        foreach (dn[i]) if (model_q.size() < n) model_q.push_back(dn[i]);
      end
    end else begin
      for (int a = 0; a <= last; a += s)
        if (n == 0 || model_q.size() < n) model_q.push_back(a);
    end
  endtask

  task automatic run_scan(input int md, input int st, input int n, input bit both,
                          input int restart_at);
    int   full, c0, cnt, done_cyc;
    bit   do_stop, got;
    logic [15:0] ck;
    if (md == 1 || md == 2) begin
      build_model(md, st, n);
      do_stop = 1'b1;
    end else begin
      build_model(md, st, 0);
      full = model_q.size();
      do_stop = 1'b0;
      if (n > 0 && n < full) begin
        build_model(md, st, n);
        do_stop = 1'b1;
      end
    end
    ck = 16'h0;
    foreach (model_q[i]) begin
      exp_data.push_back(rom[model_q[i]]);
      exp_addr.push_back(ADDR_W'(model_q[i]));
      ck += 16'(rom[model_q[i]]);
    end
`ifndef ROM_CHECKSUM_EN
    ck = 16'h0;
`endif
    check("checksum_hold", 32'(bus.checksum), 32'(prev_ck));
    first_valid_cyc = -1;
    last_valid_cyc  = -1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.stop  = both;
    bus.mode  = 2'(md);
    bus.step  = ADDR_W'(st);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 2'($urandom);
    bus.step  = ADDR_W'($urandom);
    @(negedge clk);
    c0 = cyc;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("first_rom_addr", 32'(bus.rom_addr), 32'd0);
    if (do_stop) begin
      repeat (n) @(posedge clk);
      #1 bus.stop = 1'b1;
      @(posedge clk);
      #1 bus.stop = 1'b0;
    end else if (restart_at > 0) begin
      repeat (restart_at) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    got = 1'b0;
    cnt = 0;
    done_cyc = 0;
    while (cnt < 300 && !got) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        done_cyc = cyc;
      end
      cnt++;
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("words_left", 32'(exp_data.size()), 32'd0);
      check("busy_at_done", 32'(bus.busy), 32'd0);
      check("done_after_last_valid", 32'(done_cyc), 32'(last_valid_cyc + 1));
      check("latency", 32'(first_valid_cyc - c0), 32'(RD_LAT + 1));
      check("checksum", 32'(bus.checksum), 32'(ck));
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      check("start_on_done_ignored", 32'(bus.busy), 32'd0);
      check("checksum_held", 32'(bus.checksum), 32'(ck));
    end
    exp_data.delete();
    exp_addr.delete();
    prev_ck = ck;
  endtask

  task automatic reset_mid();
    build_model(1, 3, 30);
    foreach (model_q[i]) begin
      exp_data.push_back(rom[model_q[i]]);
      exp_addr.push_back(ADDR_W'(model_q[i]));
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    bus.step  = ADDR_W'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_data_addr", 32'(bus.data_addr), 32'd0);
    check("rst_checksum", 32'(bus.checksum), 32'd0);
    exp_data.delete();
    exp_addr.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(bus.done), 32'd0);
      check("idle_after_abort", 32'(bus.busy), 32'd0);
    end
    prev_ck = 16'h0;
  endtask

  initial begin
    int md, st, n;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 2'b00;
    bus.step  = '0;
    for (int a = 0; a < 2**ADDR_W; a++) rom[a] = DATA_W'(3 * a);
    prev_ck = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_valid", 32'(bus.data_valid), 32'd0);
    check("reset_checksum", 32'(bus.checksum), 32'd0);
    reset = 1'b0;

    run_scan(0, 1, 0, 1'b0, 0);
`ifdef ROM_CHECKSUM_EN
    check("checksum_1488", 32'(bus.checksum), 32'h05D0);
`else
    check("checksum_tied", 32'(bus.checksum), 32'h0);
`endif
    run_scan(1, 5, 10, 1'b0, 0);
    run_scan(2, 4, 40, 1'b0, 0);
    run_scan(0, 0, 0, 1'b0, 6);
    run_scan(3, 7, 0, 1'b1, 0);
    reset_mid();
    run_scan(0, 1, 0, 1'b0, 0);

    for (int k = 0; k < 12; k++) begin
      for (int a = 0; a < 2**ADDR_W; a++) rom[a] = DATA_W'($urandom);
      md = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 2**ADDR_W - 1));
      if (md == 1 || md == 2) n = int'($urandom_range(1, 45));
      else n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
      run_scan(md, st, n, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
